// File: rtl/pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_regs
//  Purpose  : Control-path pipeline register chain for a 5-stage CPU
//             (F, D, E, M, W). Carries a valid bit per stage plus the
//             register addresses and control bits that the hazard unit
//             reads back. Bubbles and flushes clear the stage valid bit and
//             every control bit travelling with it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RW : register-address width (RA1/RA2/WA3 fields)
//    CW : width of the optional performance counters
//
//  Build option
//    PIPE_PERF_CNT_EN : when defined, StallCnt/FlushCnt are saturating
//                       counters; when undefined both outputs are tied to 0
//                       and no counter logic exists.
//
//  Ports
//    clk, rst_n                  clock, asynchronous active-low reset
//    InstrValidF                 fetch stage holds a valid instruction
//    StallF, StallD              hazard unit stalls (F valid, F/D register)
//    FlushD, FlushE              hazard unit flushes (bubble into D / E)
//    RA1D, RA2D, WA3D            decoder register addresses (D stage)
//    RegWriteD, MemToRegD,
//    PCSrcD                      decoder control bits (D stage)
//    CondExE                     condition check result in E
//    ValidD/E/M/W                stage valid bits
//    RA1E, RA2E, WA3E/M/W        staged register addresses
//    RegWriteE, PCSrcE           raw E-stage control (not condition-gated)
//    RegWriteM/W, PCSrcM/W       condition-qualified control
//    MemToRegE/M/W               staged load-to-register flag
//    StallCnt, FlushCnt          performance counters
// ============================================================================
module pipe_ctrl_regs #(
  parameter int RW = 6,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch / hazard unit
  input  logic          InstrValidF,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          FlushE,
  // decoder (D stage)
  input  logic [RW-1:0] RA1D,
  input  logic [RW-1:0] RA2D,
  input  logic [RW-1:0] WA3D,
  input  logic          RegWriteD,
  input  logic          MemToRegD,
  input  logic          PCSrcD,
  // execute stage condition result
  input  logic          CondExE,
  // stage valid bits
  output logic          ValidD,
  output logic          ValidE,
  output logic          ValidM,
  output logic          ValidW,
  // staged addresses
  output logic [RW-1:0] RA1E,
  output logic [RW-1:0] RA2E,
  output logic [RW-1:0] WA3E,
  output logic [RW-1:0] WA3M,
  output logic [RW-1:0] WA3W,
  // staged control
  output logic          RegWriteE,
  output logic          RegWriteM,
  output logic          RegWriteW,
  output logic          MemToRegE,
  output logic          MemToRegM,
  output logic          MemToRegW,
  output logic          PCSrcE,
  output logic          PCSrcM,
  output logic          PCSrcW,
  // performance counters
  output logic [CW-1:0] StallCnt,
  output logic [CW-1:0] FlushCnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // F stage valid
  // --------------------------------------------------------------------------
  logic valid_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_f <= 1'b0;
    end else if (!StallF) begin
      valid_f <= InstrValidF;
    end
  end

  // --------------------------------------------------------------------------
  // F/D register. A stall takes priority over a flush so that a held
  // instruction is never lost while the hazard unit is still resolving it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (FlushD) begin
      ValidD <= 1'b0;
    end else begin
      ValidD <= valid_f;
    end
  end

  // --------------------------------------------------------------------------
  // D/E register. E has no stall: during a load-use stall D holds while E
  // takes a bubble. Control bits are gated with ValidD so that a bubble in D
  // can never leak an asserted control bit into E. Addresses always load;
  // their value under a flush is don't-care.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidE    <= 1'b0;
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemToRegE <= 1'b0;
      PCSrcE    <= 1'b0;
    end else begin
      RA1E <= RA1D;
      RA2E <= RA2D;
      WA3E <= WA3D;
      if (FlushE) begin
        ValidE    <= 1'b0;
        RegWriteE <= 1'b0;
        MemToRegE <= 1'b0;
        PCSrcE    <= 1'b0;
      end else begin
        ValidE    <= ValidD;
        RegWriteE <= RegWriteD & ValidD;
        MemToRegE <= MemToRegD & ValidD;
        PCSrcE    <= PCSrcD & ValidD;
      end
    end
  end

  // --------------------------------------------------------------------------
  // E/M register. Control is qualified by the condition result here; the
  // valid bit is not, so a condition-failed instruction stays visible as a
  // valid no-op.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidM    <= 1'b0;
      WA3M      <= '0;
      RegWriteM <= 1'b0;
      MemToRegM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else begin
      ValidM    <= ValidE;
      WA3M      <= WA3E;
      RegWriteM <= RegWriteE & CondExE;
      MemToRegM <= MemToRegE & CondExE;
      PCSrcM    <= PCSrcE & CondExE;
    end
  end

  // --------------------------------------------------------------------------
  // M/W register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidW    <= 1'b0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      ValidW    <= ValidM;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      MemToRegW <= MemToRegM;
      PCSrcW    <= PCSrcM;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  // A FlushD that coincides with StallD has no effect, so it is not counted.
  logic flush_evt;
  assign flush_evt = (FlushD & ~StallD) | FlushE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_ONE;
      end
      if (flush_evt && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_ONE;
      end
    end
  end
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Control-path pipeline register chain for the 5-stage pipelined CPU (F, D, E, M, W).
- Consumes the hazard unit's StallF/StallD/FlushD/FlushE.
- Produces the per-stage register addresses and control bits the hazard unit reads back (RA1E, RA2E, WA3E/M/W, RegWriteM/W, MemToRegE, PCSrcE/M/W).
- Carries a valid bit per stage, so bubbles and flushes are architecturally visible.
- Sits between the decoder (D-stage control) and the datapath stage registers.

Parameters:
- RW, 6, register-address width for RA1/RA2/WA3 fields.
- CW, 32, width of optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- InstrValidF  in  1  fetch stage holds a valid instruction
- StallF  in  1  from hazard unit; freeze F-stage valid
- StallD  in  1  from hazard unit; hold F/D register
- FlushD  in  1  from hazard unit; bubble into D
- FlushE  in  1  from hazard unit; bubble into E
- RA1D, RA2D, WA3D  in  RW  decoder register addresses (D stage)
- RegWriteD, MemToRegD, PCSrcD  in  1  decoder control (D stage)
- CondExE  in  1  condition check result in E stage
- ValidD, ValidE, ValidM, ValidW  out  1  stage valid bits
- RA1E, RA2E, WA3E, WA3M, WA3W  out  RW  staged addresses
- RegWriteE  out  1  raw (unqualified)
- RegWriteM, RegWriteW  out  1  qualified register write
- MemToRegE, MemToRegM, MemToRegW  out  1  staged load-to-register flag
- PCSrcE  out  1  raw (unqualified)
- PCSrcM, PCSrcW  out  1  qualified PC write
- StallCnt, FlushCnt  out  CW  performance counters (see Optional Feature)

Behaviour:
- Reset: `rst_n` low asynchronously clears every register and output to 0 (all valids 0, all addresses 0, all control 0).
  - Reset mid-operation discards all in-flight state.
  - The first valid instruction after release reaches ValidW 4 cycles after it is accepted in F.
- F stage (validF register):
  - StallF=1: hold.
  - Else: validF <= InstrValidF.
- F/D register (ValidD), evaluated in this priority:
  - StallD=1: hold; FlushD is ignored while stalled (stall wins).
  - Else FlushD=1: ValidD <= 0.
  - Else: ValidD <= validF.
- D/E register, evaluated in this priority:
  - FlushE=1: ValidE, RegWriteE, MemToRegE and PCSrcE <= 0. Addresses may load the D values but are don't-care.
  - Else: load {ValidD, RA1D, RA2D, WA3D, RegWriteD&ValidD, MemToRegD&ValidD, PCSrcD&ValidD}.
  - FlushE is never blocked by a stall; E has no stall input.
- E/M register, always advances:
  - ValidM <= ValidE.
  - WA3M <= WA3E.
  - RegWriteM <= RegWriteE & CondExE.
  - PCSrcM <= PCSrcE & CondExE.
  - MemToRegM <= MemToRegE & CondExE.
- M/W register, always advances: copy the M fields to W.
- Invariants:
  - Any control bit at a stage implies that stage's valid bit.
  - A bubble never asserts RegWrite, MemToReg or PCSrc.
- Simultaneous StallD=1 and FlushE=1 (load-use stall):
  - D holds its contents.
  - E receives a bubble.
  - M/W advance.
- Latency: a D-stage instruction appears on the E outputs after 1 clk, M after 2, W after 3, absent stalls/flushes.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - StallCnt increments once per cycle with StallD=1.
  - FlushCnt increments once per cycle with (FlushD & ~StallD) | FlushE.
  - Both counters saturate at all-ones, never wrap, and clear on reset.
- Undefined: StallCnt and FlushCnt are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset mid-stream: 3 valid instructions in flight, pulse rst_n low between clock edges -> all outputs 0 immediately; after release, ValidW stays 0 until 4 clk after the next InstrValidF.
- Straight-line flow: RA1D=5, RA2D=6, WA3D=7, RegWriteD=1, CondExE=1 -> RA1E=5 and RA2E=6 after 1 clk, WA3M=7 and RegWriteM=1 after 2 clk, WA3W=7 and RegWriteW=1 after 3 clk.
- Load-use: StallF=StallD=FlushE=1 for one cycle with MemToRegD=1 in D -> ValidE=0 and MemToRegE=0 that cycle; the D contents re-enter E on the next cycle unchanged.
- Stall vs flush: StallD=1 and FlushD=1 in the same cycle -> ValidD holds 1; next cycle FlushD=1 only -> ValidD=0.
- Condition fail: PCSrcE=1, RegWriteE=1, CondExE=0 -> PCSrcM=0 and RegWriteM=0 while ValidM=1.
- Counters (PIPE_PERF_CNT_EN defined): 5 cycles of StallD plus 2 cycles of FlushE -> StallCnt=5, FlushCnt=2; with the macro undefined both read 0.
